// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM link constants and decoder state type
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = 2 ** PWM_WIDTH;

  typedef enum logic {
    WAIT_EDGE,
    MEASURE
  } pwm_dec_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - PWM line synchronizer and rise detect
// PWM_DECODER_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronizer.
module pwm_in_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic s_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      s_d1   <= 1'b0;
    end else begin
      meta_q <= pwm_in;
      sync_q <= meta_q;
      s_d1   <= s;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], sync_q};
    end
  end

  // Level moves only once three consecutive synced samples agree; s_d1 holds it otherwise.
  always_comb begin
    s = s_d1;
    if (sync_q && (&hist_q)) begin
      s = 1'b1;
    end else if (!sync_q && !(|hist_q)) begin
      s = 1'b0;
    end
  end
`else
  assign s = sync_q;
`endif

  assign rise = s & ~s_d1;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - recovers duty, period error and stuck status from a PWM line
// Optional PWM_DECODER_GLITCH_FILTER_EN enables the input glitch filter in pwm_in_sync.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int WIDTH           = PWM_WIDTH,
  parameter int TIMEOUT_PERIODS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_valid,
  output logic             period_err,
  output logic             stuck
);

  localparam int CNT_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] NOMINAL     = CNT_W'(2 ** WIDTH);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_PERIODS * (2 ** WIDTH));

  logic s;
  logic rise;
  logic timeout;

  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;

  pwm_dec_state_e   state_q;
  pwm_dec_state_e   state_d;
  logic [WIDTH-1:0] duty_d;
  logic             valid_d;
  logic             perr_d;
  logic             stuck_d;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise)
  );

  // Counters restart at 1 on a rise so that at the next rise they hold period and high time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + 1'b1;
      end
      if (s && (hi_cnt != CNT_MAX)) begin
        hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end

  assign timeout = (per_cnt == TIMEOUT_CNT);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_out;
    valid_d = 1'b0;
    perr_d  = period_err;
    stuck_d = stuck;
    if (rise) begin
      state_d = MEASURE;
      stuck_d = 1'b0;
      if (state_q == MEASURE) begin
        valid_d = 1'b1;
        duty_d  = (hi_cnt < NOMINAL) ? hi_cnt[WIDTH-1:0] : '1;
        perr_d  = (per_cnt != NOMINAL);
      end
    end else if (timeout) begin
      // A line stuck at the current level reads as duty 0 or full scale.
      state_d = WAIT_EDGE;
      stuck_d = 1'b1;
      valid_d = 1'b1;
      duty_d  = {WIDTH{s}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_EDGE;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_out   <= duty_d;
      duty_valid <= valid_d;
      period_err <= perr_d;
      stuck      <= stuck_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - self-checking bench for pwm_duty_decoder
module tb_pwm_duty_decoder;
  import pwm_pkg::*;

  localparam int W   = PWM_WIDTH;
  localparam int NOM = PWM_PERIOD;
  localparam int TMO = 2 * NOM;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int LAT         = 4;
  localparam int GLITCH_PERR = 0;
`else
  localparam int LAT         = 2;
  localparam int GLITCH_PERR = 2;
`endif

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] duty_out;
  logic         duty_valid;
  logic         period_err;
  logic         stuck;

  int tests = 0;
  int fails = 0;

  pwm_duty_decoder #(
    .WIDTH           (W),
    .TIMEOUT_PERIODS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .period_err (period_err),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: timestamps of level rises and sums over the sampled line history.
  int edge_cnt = 0;
  bit p_q[$];
  bit s_q[$];
  int m_last   = 0;
  bit m_armed  = 0;
  int exp_duty = 0;
  bit exp_dv   = 0;
  bit exp_perr = 0;
  bit exp_stuck = 0;

  task automatic model_step();
    int n, per, hi;
    bit y, s, sp, rise;
    n = p_q.size();
    p_q.push_back(pwm_in);
    y = (n >= 2) ? p_q[n-2] : 1'b0;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    begin
      bit y1, y2, hold;
      y1   = (n >= 3) ? p_q[n-3] : 1'b0;
      y2   = (n >= 4) ? p_q[n-4] : 1'b0;
      hold = (n >= 1) ? s_q[n-1] : 1'b0;
      s    = (y == y1 && y1 == y2) ? y : hold;
    end
`else
    s = y;
`endif
    sp = (n >= 1) ? s_q[n-1] : 1'b0;
    s_q.push_back(s);
    rise = s && !sp;
    exp_dv = 1'b0;
    if (rise) begin
      if (m_armed) begin
        per = n - m_last;
        hi  = 0;
        for (int k = m_last; k < n; k++) hi += int'(s_q[k]);
        exp_dv   = 1'b1;
        exp_duty = (hi >= NOM) ? NOM - 1 : hi;
        exp_perr = (per != NOM);
      end
      m_armed   = 1'b1;
      exp_stuck = 1'b0;
      m_last    = n;
    end else if (n - m_last == TMO) begin
      exp_dv    = 1'b1;
      exp_stuck = 1'b1;
      exp_duty  = s ? NOM - 1 : 0;
      m_armed   = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
    if (!rst_n) begin
      p_q.delete();
      s_q.delete();
      m_last    = 0;
      m_armed   = 1'b0;
      exp_duty  = 0;
      exp_dv    = 1'b0;
      exp_perr  = 1'b0;
      exp_stuck = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle compare plus event log used by the directed checks.
  int dv_edges[$];
  int perr_cnt   = 0;
  int stuck_edge = 0;
  bit stuck_prev = 0;

  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      check("cyc_duty_out",   int'(duty_out),   exp_duty);
      check("cyc_duty_valid", int'(duty_valid), int'(exp_dv));
      check("cyc_period_err", int'(period_err), int'(exp_perr));
      check("cyc_stuck",      int'(stuck),      int'(exp_stuck));
      if (duty_valid) begin
        dv_edges.push_back(edge_cnt);
        if (period_err) perr_cnt++;
      end
      if (stuck && !stuck_prev) stuck_edge = edge_cnt;
      stuck_prev = stuck;
    end
  end

  int call_first_rise = 0;
  int last_rise       = 0;

  task automatic run_pwm(input int period, input int high, input int count);
    for (int i = 0; i < count; i++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        pwm_in = (c < high);
        if (c == 0 && high > 0) begin
          last_rise = edge_cnt + 1;
          if (i == 0) call_first_rise = edge_cnt + 1;
        end
      end
    end
  endtask

  task automatic hold(input bit level, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      pwm_in = level;
    end
  endtask

  task automatic run_glitch();
    for (int c = 0; c < NOM; c++) begin
      @(negedge clk);
      pwm_in = (c < 64) || (c == 150);
    end
  endtask

  task automatic check_first_dv(input string name, input int base, input int exp_edge);
    if (dv_edges.size() > base) begin
      check(name, dv_edges[base], exp_edge);
    end else begin
      check(name, -1, exp_edge);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_duty_out",   int'(duty_out),   0);
    check("reset_duty_valid", int'(duty_valid), 0);
    check("reset_period_err", int'(period_err), 0);
    check("reset_stuck",      int'(stuck),      0);
    rst_n = 1'b1;

    base = dv_edges.size();
    run_pwm(NOM, 64, 5);
    check_first_dv("first_valid_edge", base, call_first_rise + NOM + LAT);
    check("dv_count_64", dv_edges.size() - base, 4);
    check("dv_spacing", dv_edges[$] - dv_edges[$-1], NOM);
    check("duty_64", int'(duty_out), 64);
    check("perr_64", int'(period_err), 0);

    run_pwm(NOM, 200, 3);
    check("duty_200", int'(duty_out), 200);
    run_pwm(NOM, 1, 3);
    check("duty_1", int'(duty_out), 1);
    run_pwm(NOM, 255, 3);
    check("duty_255", int'(duty_out), 255);

    run_pwm(NOM, 10, 2);
    hold(1'b0, 600);
    check("stuck_low", int'(stuck), 1);
    check("stuck_low_duty", int'(duty_out), 0);
    check("stuck_timing", stuck_edge - (last_rise + LAT), TMO);
    hold(1'b1, 600);
    check("stuck_high", int'(stuck), 1);
    check("stuck_high_duty", int'(duty_out), 255);
    hold(1'b0, 50);
    base = dv_edges.size();
    run_pwm(NOM, 10, 1);
    check("stuck_clear_first_rise", int'(stuck), 0);
    check("arm_only_no_dv", dv_edges.size() - base, 0);
    run_pwm(NOM, 10, 2);
    check("duty_10_resume", int'(duty_out), 10);

    run_pwm(200, 50, 3);
    check("short_period_duty", int'(duty_out), 50);
    check("short_period_err", int'(period_err), 1);
    run_pwm(NOM, 50, 3);
    check("nominal_period_duty", int'(duty_out), 50);
    check("nominal_period_err", int'(period_err), 0);

    run_pwm(NOM, 64, 1);
    hold(1'b0, 100);
    check("pre_reset_duty", int'(duty_out), 50);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_duty_out",   int'(duty_out),   0);
    check("async_reset_duty_valid", int'(duty_valid), 0);
    check("async_reset_period_err", int'(period_err), 0);
    check("async_reset_stuck",      int'(stuck),      0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = dv_edges.size();
    run_pwm(NOM, 64, 3);
    check_first_dv("post_reset_first_valid", base, call_first_rise + NOM + LAT);
    check("post_reset_dv_count", dv_edges.size() - base, 2);
    check("post_reset_duty", int'(duty_out), 64);

    run_pwm(NOM, 64, 2);
    base = perr_cnt;
    run_glitch();
    run_pwm(NOM, 64, 3);
    check("glitch_perr_pulses", perr_cnt - base, GLITCH_PERR);
    check("glitch_final_duty", int'(duty_out), 64);
    check("glitch_final_perr", int'(period_err), 0);

    repeat (4) @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
